// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the Common Data Bus arbiter.
// Holds the FU count, the tag type, the dummy-tag constant, the FU slot indices
// and a population-count helper that sizes the occupancy counter.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU = 5;
    localparam int unsigned TAG_W  = 7;
    localparam int unsigned PTR_W  = $clog2(NUM_FU);

    // Bit 6 is the ready bit, bits 5:0 are the physical register number.
    typedef logic [TAG_W-1:0] phys_reg_t;

    localparam phys_reg_t DUMMY_TAG = 7'b1111111;

    localparam int unsigned FU_ALU_IDX  = 0;
    localparam int unsigned FU_LD_IDX   = 1;
    localparam int unsigned FU_ST_IDX   = 2;
    localparam int unsigned FU_MULT_IDX = 3;
    localparam int unsigned FU_BR_IDX   = 4;

    function automatic logic [PTR_W:0] popcount(input logic [NUM_FU-1:0] v);
        logic [PTR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            c = c + {{PTR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-completion / CDB bus bundle for cdb_arbiter.
// Signals:
//   fu_done_valid    FU i presents a completed tag
//   fu_done_tag      packed tags, FU i in bits [i*TAG_W +: TAG_W]
//   fu_done_ready    slot i accepts this cycle (combinational)
//   branch_not_taken squash/flush request
//   CDB_out          registered broadcast tag
//   cdb_valid        CDB_out is valid
//   CAM_en           RS tag CAM enable, mirrors cdb_valid
//   pend_cnt         number of occupied holding slots
// Modports: master = FU/ROB side, slave = arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_FU-1:0]       fu_done_valid;
    logic [NUM_FU*TAG_W-1:0] fu_done_tag;
    logic [NUM_FU-1:0]       fu_done_ready;
    logic                    branch_not_taken;
    phys_reg_t               CDB_out;
    logic                    cdb_valid;
    logic                    CAM_en;
    logic [PTR_W:0]          pend_cnt;

    modport master (
        output fu_done_valid, fu_done_tag, branch_not_taken,
        input  fu_done_ready, CDB_out, cdb_valid, CAM_en, pend_cnt
    );

    modport slave (
        input  fu_done_valid, fu_done_tag, branch_not_taken,
        output fu_done_ready, CDB_out, cdb_valid, CAM_en, pend_cnt
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin single-grant arbiter.
// Ports:
//   req_i      request vector
//   ptr_i      index with highest priority this cycle
//   gnt_o      one-hot grant
//   gnt_idx_o  binary index of the grant (0 when none)
//   any_o      at least one grant
// The request vector is duplicated so a scan of N bits starting at ptr_i covers
// the wrap from N-1 to 0 without a separate case.
module rr_arbiter #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 any_o
);

    localparam int unsigned PtrW = $clog2(N);
    localparam int unsigned IdxW = $clog2(2 * N);

    logic [2*N-1:0]  dbl;
    logic [2*N-1:0]  gnt_dbl;
    logic [IdxW-1:0] pos;
    logic            found;

    always_comb begin
        dbl     = {req_i, req_i};
        gnt_dbl = '0;
        pos     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IdxW'(ptr_i) + IdxW'(k);
            if (!found && dbl[pos]) begin
                found        = 1'b1;
                gnt_dbl[pos] = 1'b1;
            end
        end
        // Fold the upper copy back onto the real slot positions.
        gnt_o     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_o[i]) begin
                gnt_idx_o = PtrW'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter.
// Each FU deposits a completed tag into a one-entry holding slot; one slot per
// cycle is picked round-robin and broadcast on the registered CDB. A branch
// squash empties all slots and the bus.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    cdb_arbiter_if.slave (FU handshake, flush, CDB outputs, pend_cnt)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input logic          clock,
    input logic          reset,
    cdb_arbiter_if.slave bus
);

    logic [NUM_FU-1:0] hold_v_q, hold_v_d;
    phys_reg_t         hold_tag_q [NUM_FU];
    phys_reg_t         hold_tag_d [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    phys_reg_t         cdb_out_q, cdb_out_d;
    logic [PTR_W:0]    pend_cnt_q, pend_cnt_d;

    logic [NUM_FU-1:0] arb_gnt, gnt, ready;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any, any, flush;
    phys_reg_t         tag_in;

    assign flush = bus.branch_not_taken;

    rr_arbiter #(
        .N(NUM_FU)
    ) u_rr (
        .req_i    (hold_v_q),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_idx_o(arb_idx),
        .any_o    (arb_any)
    );

    // A flush suppresses the grant so nothing leaks onto the bus that cycle.
    assign gnt   = flush ? '0 : arb_gnt;
    assign any   = arb_any & ~flush;
    // A slot being granted this cycle can take a new tag at the same edge.
    assign ready = {NUM_FU{~reset & ~flush}} & (~hold_v_q | gnt);

    always_comb begin
        hold_v_d    = hold_v_q & ~gnt;
        hold_tag_d  = hold_tag_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_out_d   = DUMMY_TAG;
        tag_in      = '0;

        if (any) begin
            cdb_valid_d = 1'b1;
            cdb_out_d   = {1'b1, hold_tag_q[arb_idx][TAG_W-2:0]};
            rr_ptr_d    = (arb_idx == PTR_W'(NUM_FU - 1)) ? '0 : arb_idx + PTR_W'(1);
        end

        for (int i = 0; i < NUM_FU; i++) begin
            tag_in = bus.fu_done_tag[i*TAG_W +: TAG_W];
            // Dummy tags are handshaken away but never occupy a slot.
            if (bus.fu_done_valid[i] && ready[i] &&
                tag_in[TAG_W-2:0] != DUMMY_TAG[TAG_W-2:0]) begin
                hold_v_d[i]   = 1'b1;
                hold_tag_d[i] = tag_in;
            end
        end

        if (flush) begin
            hold_v_d = '0;
        end

        pend_cnt_d = popcount(hold_v_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_v_q    <= '0;
            hold_tag_q  <= '{default: '0};
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= DUMMY_TAG;
            pend_cnt_q  <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_tag_q  <= hold_tag_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_out_q   <= cdb_out_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    assign bus.fu_done_ready = ready;
    assign bus.CDB_out       = cdb_out_q;
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.CAM_en        = cdb_valid_q;
    assign bus.pend_cnt      = pend_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with fixed expected
// values plus a randomized run checked against a slot/queue-level model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock;
    logic reset;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: set of occupied slots, their tags, next priority index.
    bit         m_v   [NUM_FU];
    logic [6:0] m_tag [NUM_FU];
    int         m_ptr;
    logic       m_cdbv;
    logic [6:0] m_cdb;

    logic [NUM_FU-1:0]       cur_v;
    logic [NUM_FU*TAG_W-1:0] cur_tags;
    logic                    cur_bnt;

    function automatic int m_grant();
        int j;
        if (cur_bnt) return -1;
        for (int k = 0; k < NUM_FU; k++) begin
            j = (m_ptr + k) % NUM_FU;
            if (m_v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NUM_FU-1:0] m_ready();
        logic [NUM_FU-1:0] r;
        int g;
        g = m_grant();
        for (int i = 0; i < NUM_FU; i++) r[i] = !cur_bnt && (!m_v[i] || g == i);
        return r;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NUM_FU; i++) c += int'(m_v[i]);
        return c;
    endfunction

    function automatic logic [NUM_FU*TAG_W-1:0] tag_at(input int i, input logic [6:0] t);
        logic [NUM_FU*TAG_W-1:0] r;
        r = '0;
        r[i*TAG_W +: TAG_W] = t;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
        end
        m_ptr  = 0;
        m_cdbv = 1'b0;
        m_cdb  = 7'h7F;
    endtask

    // Called just after a rising edge; leaves time at the falling edge.
    task automatic apply(input logic [NUM_FU-1:0] v, input logic [NUM_FU*TAG_W-1:0] tags,
                         input logic bnt);
        cur_v                = v;
        cur_tags             = tags;
        cur_bnt              = bnt;
        bus.fu_done_valid    = v;
        bus.fu_done_tag      = tags;
        bus.branch_not_taken = bnt;
        #4;
    endtask

    task automatic advance();
        int                g;
        logic [NUM_FU-1:0] r;
        logic [6:0]        t;
        g = m_grant();
        r = m_ready();
        @(posedge clock);
        if (g >= 0) begin
            m_cdbv   = 1'b1;
            m_cdb    = {1'b1, m_tag[g][5:0]};
            m_v[g]   = 1'b0;
            m_ptr    = (g + 1) % NUM_FU;
        end else begin
            m_cdbv = 1'b0;
            m_cdb  = 7'h7F;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            t = cur_tags[i*TAG_W +: TAG_W];
            if (cur_v[i] && r[i] && t[5:0] != 6'h3F) begin
                m_v[i]   = 1'b1;
                m_tag[i] = t;
            end
        end
        if (cur_bnt) for (int i = 0; i < NUM_FU; i++) m_v[i] = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        bus.fu_done_valid    = '0;
        bus.fu_done_tag      = '0;
        bus.branch_not_taken = 1'b0;
        m_reset();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL reset_cdb_valid got %b want 0", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.CDB_out !== 7'h7F) $display("FAIL reset_cdb_out got %h want 7f", bus.CDB_out); else n_pass++;
        n_checks++; if (bus.fu_done_ready !== 5'b11111) $display("FAIL reset_ready got %b want 11111", bus.fu_done_ready); else n_pass++;
        n_checks++; if (bus.pend_cnt !== 4'd0) $display("FAIL reset_pend got %0d want 0", bus.pend_cnt); else n_pass++;
        n_checks++; if (bus.CAM_en !== 1'b0) $display("FAIL reset_cam_en got %b want 0", bus.CAM_en); else n_pass++;
        advance();
    endtask

    task automatic test_single();
        apply(5'b00010, tag_at(1, 7'h05), 1'b0);
        n_checks++; if (bus.fu_done_ready !== 5'b11111) $display("FAIL single_ready got %b want 11111", bus.fu_done_ready); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.pend_cnt !== 4'd1) $display("FAIL single_pend got %0d want 1", bus.pend_cnt); else n_pass++;
        n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL single_early got %b want 0", bus.cdb_valid); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.CDB_out !== 7'h45) $display("FAIL single_cdb got %h want 45", bus.CDB_out); else n_pass++;
        n_checks++; if (bus.cdb_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.CAM_en !== 1'b1) $display("FAIL single_cam_en got %b want 1", bus.CAM_en); else n_pass++;
        n_checks++; if (bus.pend_cnt !== 4'd0) $display("FAIL single_pend0 got %0d want 0", bus.pend_cnt); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL single_one_cycle got %b want 0", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.CDB_out !== 7'h7F) $display("FAIL single_dummy got %h want 7f", bus.CDB_out); else n_pass++;
        advance();
        // Priority now starts at 2, so slot 3 must beat slot 0.
        apply(5'b01001, tag_at(0, 7'h21) | tag_at(3, 7'h23), 1'b0);
        advance();
        apply('0, '0, 1'b0);
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.CDB_out !== 7'h63) $display("FAIL ptr_first got %h want 63", bus.CDB_out); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.CDB_out !== 7'h61) $display("FAIL ptr_second got %h want 61", bus.CDB_out); else n_pass++;
        advance();
    endtask

    task automatic test_all_five();
        logic [6:0]        exp_cdb [7] = '{7'h7F, 7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h7F};
        logic              exp_v   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]        exp_pend[7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic [NUM_FU-1:0] exp_rdy [7] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                           5'b11111, 5'b11111, 5'b11111};
        logic [NUM_FU*TAG_W-1:0] tg;
        do_reset();
        tg = '0;
        for (int i = 0; i < NUM_FU; i++) tg = tg | tag_at(i, 7'(i + 1));
        apply(5'b11111, tg, 1'b0);
        n_checks++; if (bus.fu_done_ready !== 5'b11111) $display("FAIL all5_ready0 got %b want 11111", bus.fu_done_ready); else n_pass++;
        advance();
        for (int c = 0; c < 7; c++) begin
            apply('0, '0, 1'b0);
            n_checks++; if (bus.pend_cnt !== exp_pend[c]) $display("FAIL all5_pend[%0d] got %0d want %0d", c, bus.pend_cnt, exp_pend[c]); else n_pass++;
            n_checks++; if (bus.cdb_valid !== exp_v[c]) $display("FAIL all5_valid[%0d] got %b want %b", c, bus.cdb_valid, exp_v[c]); else n_pass++;
            n_checks++; if (bus.CDB_out !== exp_cdb[c]) $display("FAIL all5_cdb[%0d] got %h want %h", c, bus.CDB_out, exp_cdb[c]); else n_pass++;
            n_checks++; if (bus.fu_done_ready !== exp_rdy[c]) $display("FAIL all5_ready[%0d] got %b want %b", c, bus.fu_done_ready, exp_rdy[c]); else n_pass++;
            advance();
        end
    endtask

    task automatic test_fairness();
        int                n0 = 0;
        int                n4 = 0;
        logic [NUM_FU-1:0] r;
        logic [1:0]        want_src;
        // Walk the pointer to 3 by granting slot 2.
        apply(5'b00100, tag_at(2, 7'h07), 1'b0);
        advance();
        apply('0, '0, 1'b0);
        advance();
        for (int c = 0; c < 12; c++) begin
            apply(5'b10001, tag_at(0, 7'(32'h10 + n0)) | tag_at(4, 7'(32'h20 + n4)), 1'b0);
            r = m_ready();
            n_checks++; if (bus.fu_done_ready !== r) $display("FAIL fair_ready[%0d] got %b want %b", c, bus.fu_done_ready, r); else n_pass++;
            n_checks++; if (bus.CDB_out !== m_cdb) $display("FAIL fair_cdb[%0d] got %h want %h", c, bus.CDB_out, m_cdb); else n_pass++;
            if (c >= 2) begin
                want_src = (c % 2 == 0) ? 2'b10 : 2'b01;
                n_checks++; if (bus.cdb_valid !== 1'b1 || bus.CDB_out[5:4] !== want_src) $display("FAIL fair_order[%0d] got valid %b src %b want valid 1 src %b", c, bus.cdb_valid, bus.CDB_out[5:4], want_src); else n_pass++;
            end
            advance();
            if (r[0]) n0++;
            if (r[4]) n4++;
        end
        for (int c = 0; c < 3; c++) begin
            apply('0, '0, 1'b0);
            advance();
        end
    endtask

    task automatic test_flush();
        apply(5'b01101, tag_at(0, 7'h11) | tag_at(2, 7'h12) | tag_at(3, 7'h13), 1'b0);
        advance();
        apply(5'b10000, tag_at(4, 7'h09), 1'b1);
        n_checks++; if (bus.fu_done_ready !== 5'b00000) $display("FAIL flush_ready got %b want 00000", bus.fu_done_ready); else n_pass++;
        n_checks++; if (bus.pend_cnt !== 4'd3) $display("FAIL flush_pend_before got %0d want 3", bus.pend_cnt); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.pend_cnt !== 4'd0) $display("FAIL flush_pend got %0d want 0", bus.pend_cnt); else n_pass++;
        n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.CDB_out !== 7'h7F) $display("FAIL flush_cdb got %h want 7f", bus.CDB_out); else n_pass++;
        n_checks++; if (bus.fu_done_ready !== 5'b11111) $display("FAIL flush_ready_after got %b want 11111", bus.fu_done_ready); else n_pass++;
        advance();
        for (int c = 0; c < 4; c++) begin
            apply('0, '0, 1'b0);
            n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL flush_quiet[%0d] got %b want 0 (cdb %h)", c, bus.cdb_valid, bus.CDB_out); else n_pass++;
            advance();
        end
    endtask

    task automatic test_dummy();
        apply(5'b00100, tag_at(2, 7'h3F), 1'b0);
        n_checks++; if (bus.fu_done_ready[2] !== 1'b1) $display("FAIL dummy_ready got %b want 1", bus.fu_done_ready[2]); else n_pass++;
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.pend_cnt !== 4'd0) $display("FAIL dummy_pend got %0d want 0", bus.pend_cnt); else n_pass++;
        advance();
        for (int c = 0; c < 3; c++) begin
            apply('0, '0, 1'b0);
            n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL dummy_quiet[%0d] got %b want 0 (cdb %h)", c, bus.cdb_valid, bus.CDB_out); else n_pass++;
            advance();
        end
    endtask

    task automatic test_async_reset();
        apply(5'b01010, tag_at(1, 7'h0A) | tag_at(3, 7'h0C), 1'b0);
        advance();
        apply('0, '0, 1'b0);
        advance();
        apply('0, '0, 1'b0);
        n_checks++; if (bus.cdb_valid !== 1'b1) $display("FAIL areset_pre_valid got %b want 1", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.pend_cnt !== 4'd1) $display("FAIL areset_pre_pend got %0d want 1", bus.pend_cnt); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", bus.cdb_valid); else n_pass++;
        n_checks++; if (bus.pend_cnt !== 4'd0) $display("FAIL areset_pend got %0d want 0", bus.pend_cnt); else n_pass++;
        n_checks++; if (bus.CAM_en !== 1'b0) $display("FAIL areset_cam_en got %b want 0", bus.CAM_en); else n_pass++;
        n_checks++; if (bus.CDB_out !== 7'h7F) $display("FAIL areset_cdb got %h want 7f", bus.CDB_out); else n_pass++;
        m_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply('0, '0, 1'b0);
            n_checks++; if (bus.cdb_valid !== 1'b0) $display("FAIL areset_quiet[%0d] got %b want 0 (cdb %h)", c, bus.cdb_valid, bus.CDB_out); else n_pass++;
            advance();
        end
    endtask

    task automatic test_random();
        logic                    pv [NUM_FU];
        logic [6:0]              pt [NUM_FU];
        logic [NUM_FU-1:0]       v, r;
        logic [NUM_FU*TAG_W-1:0] tg;
        logic                    bnt;
        for (int i = 0; i < NUM_FU; i++) begin
            pv[i] = 1'b0;
            pt[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            v  = '0;
            tg = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pt[i] = 7'($urandom_range(0, 127));
                    if ($urandom_range(0, 7) == 0) pt[i][5:0] = 6'h3F;
                end
                v[i] = pv[i];
                tg   = tg | tag_at(i, pt[i]);
            end
            bnt = ($urandom_range(0, 15) == 0);
            apply(v, tg, bnt);
            r = m_ready();
            n_checks++; if (bus.fu_done_ready !== r) $display("FAIL rand_ready[%0d] got %b want %b", c, bus.fu_done_ready, r); else n_pass++;
            n_checks++; if (bus.CDB_out !== m_cdb) $display("FAIL rand_cdb[%0d] got %h want %h", c, bus.CDB_out, m_cdb); else n_pass++;
            n_checks++; if (bus.cdb_valid !== m_cdbv) $display("FAIL rand_valid[%0d] got %b want %b", c, bus.cdb_valid, m_cdbv); else n_pass++;
            n_checks++; if (bus.CAM_en !== m_cdbv) $display("FAIL rand_cam_en[%0d] got %b want %b", c, bus.CAM_en, m_cdbv); else n_pass++;
            n_checks++; if (bus.pend_cnt !== 4'(m_count())) $display("FAIL rand_pend[%0d] got %0d want %0d", c, bus.pend_cnt, m_count()); else n_pass++;
            advance();
            for (int i = 0; i < NUM_FU; i++) if (pv[i] && r[i]) pv[i] = 1'b0;
        end
    endtask

    initial begin
        reset                = 1'b1;
        bus.fu_done_valid    = '0;
        bus.fu_done_tag      = '0;
        bus.branch_not_taken = 1'b0;
        cur_v                = '0;
        cur_tags             = '0;
        cur_bnt              = 1'b0;
        m_reset();
        test_reset();
        test_single();
        test_all_five();
        test_fairness();
        test_flush();
        test_dummy();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
